// File: rtl/ldpc_code_pkg.sv
// Hamming(7,4) code parameters, parity masks and encoder state encoding.
// Mask rows are MSB-first in message order: bit K-1 selects m0.
package ldpc_code_pkg;
    localparam int K        = 4;
    localparam int N_V      = 7;
    localparam int N_P      = N_V - K;
    localparam int INT_SIZE = $clog2(N_V + 1);

    // p0 = m0^m1^m3, p1 = m0^m2^m3, p2 = m1^m2^m3
    localparam logic [N_P-1:0][K-1:0] PARITY_MASK = {4'b0111, 4'b1011, 4'b1101};

    typedef enum logic [1:0] {
        RESET  = 2'd0,
        READ   = 2'd1,
        ENCODE = 2'd2,
        WRITE  = 2'd3
    } state_e;
endpackage

// File: rtl/axi_stream_if.sv
// AXI-stream bundle; WIDTH sets the tdata width seen by the attached modules.
interface axi_stream_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ldpc_parity_unit.sv
// Combinational single parity bit: XOR of the message bits selected by mask row idx_i.
module ldpc_parity_unit
    import ldpc_code_pkg::*;
(
    input  logic [K-1:0]        msg_i,
    input  logic [INT_SIZE-1:0] idx_i,
    output logic                parity_o
);
    logic [K-1:0] row;

    always_comb begin
        row = '0;
        for (int j = 0; j < N_P; j++) begin
            if (idx_i == INT_SIZE'(j)) row = PARITY_MASK[j];
        end
        parity_o = ^(msg_i & row);
    end
endmodule

// File: rtl/ldpc_encoder_top.sv
// Systematic LDPC encoder: read K bits, one parity bit per cycle for N_P cycles, then
// stream the codeword MSB-first; input stalls (tready=0) from last input beat to last output beat.
module ldpc_encoder_top
    import ldpc_code_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    axi_stream_if.slave  from_env,
    axi_stream_if.master to_env
);
    localparam int W_IN       = $bits(from_env.tdata);
    localparam int W_OUT      = $bits(to_env.tdata);
    localparam int IN_ITER_N  = (K + W_IN - 1) / W_IN;
    localparam int OUT_ITER_N = (N_V + W_OUT - 1) / W_OUT;
    localparam int OUT_PAD    = (N_V - 1) % W_OUT + 1;

    state_e              state_q;
    logic [K-1:0]        msg_q, msg_d;
    logic [N_P-1:0]      parity_q, parity_d;
    logic [N_V-1:0]      out_q, out_d;
    logic [INT_SIZE-1:0] seg_cnt_q, p_cnt_q;
    logic                tready_q, tvalid_q, tlast_q;
    logic                p_bit;
    logic [W_OUT-1:0]    beat0;

    ldpc_parity_unit u_parity (
        .msg_i    (msg_q),
        .idx_i    (p_cnt_q),
        .parity_o (p_bit)
    );

    always_comb begin
        msg_d    = (msg_q << W_IN) | K'(from_env.tdata);
        parity_d = parity_q;
        // p_j lands at codeword bit K+j, i.e. parity register bit N_P-1-j
        for (int j = 0; j < N_P; j++) begin
            if (p_cnt_q == INT_SIZE'(j)) parity_d[N_P-1-j] = p_bit;
        end
        out_d = (seg_cnt_q == '0) ? (out_q << OUT_PAD) : (out_q << W_OUT);
        beat0 = W_OUT'(out_q[N_V-1 -: OUT_PAD]);
    end

    assign from_env.tready = tready_q;
    assign to_env.tvalid   = tvalid_q;
    assign to_env.tlast    = tlast_q;
    assign to_env.tdata    = !tvalid_q ? '0 :
                             (seg_cnt_q == '0) ? beat0 : out_q[N_V-1 -: W_OUT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RESET;
            msg_q     <= '0;
            parity_q  <= '0;
            out_q     <= '0;
            seg_cnt_q <= '0;
            p_cnt_q   <= '0;
            tready_q  <= 1'b0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
        end else begin
            case (state_q)
                RESET: begin
                    state_q  <= READ;
                    tready_q <= 1'b1;
                end
                READ: begin
                    if (from_env.tvalid && tready_q) begin
                        msg_q <= msg_d;
                        if (seg_cnt_q == INT_SIZE'(IN_ITER_N - 1)) begin
                            seg_cnt_q <= '0;
                            tready_q  <= 1'b0;
                            state_q   <= ENCODE;
                        end else begin
                            seg_cnt_q <= seg_cnt_q + 1'b1;
                        end
                    end
                end
                ENCODE: begin
                    parity_q <= parity_d;
                    if (p_cnt_q == INT_SIZE'(N_P - 1)) begin
                        p_cnt_q  <= '0;
                        out_q    <= {msg_q, parity_d};
                        tvalid_q <= 1'b1;
                        tlast_q  <= (OUT_ITER_N == 1);
                        state_q  <= WRITE;
                    end else begin
                        p_cnt_q <= p_cnt_q + 1'b1;
                    end
                end
                WRITE: begin
                    if (to_env.tready) begin
                        if (seg_cnt_q == INT_SIZE'(OUT_ITER_N - 1)) begin
                            seg_cnt_q <= '0;
                            out_q     <= '0;
                            tvalid_q  <= 1'b0;
                            tlast_q   <= 1'b0;
                            tready_q  <= 1'b1;
                            state_q   <= READ;
                        end else begin
                            out_q     <= out_d;
                            seg_cnt_q <= seg_cnt_q + 1'b1;
                            tlast_q   <= (seg_cnt_q == INT_SIZE'(OUT_ITER_N - 2));
                        end
                    end
                end
                default: state_q <= RESET;
            endcase
        end
    end
endmodule

// File: tb/tb_ldpc_encoder_top.sv
// Bench for ldpc_encoder_top: Hamming(7,4) with W_IN=4 (dut_a) and W_IN=2 (dut_b).
module tb_ldpc_encoder_top;
    import ldpc_code_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_stream_if #(.WIDTH(4)) a_in ();
    axi_stream_if #(.WIDTH(4)) a_out ();
    axi_stream_if #(.WIDTH(2)) b_in ();
    axi_stream_if #(.WIDTH(4)) b_out ();

    ldpc_encoder_top dut_a (.clk(clk), .rst(rst), .from_env(a_in.slave), .to_env(a_out.master));
    ldpc_encoder_top dut_b (.clk(clk), .rst(rst), .from_env(b_in.slave), .to_env(b_out.master));

    typedef struct packed {
        logic [3:0] d;
        logic       l;
    } beat_t;

    typedef struct {
        logic [3:0] msg;
        logic [3:0] b0;
        logic [3:0] b1;
    } vec_t;

    int    n_cmp = 0;
    int    n_err = 0;
    int    frames = 0;
    beat_t exp_q[$];
    logic  use_b = 1'b0;
    int    rdy_mode = 0;
    int    stall = 0;
    logic  out_rdy = 1'b1;
    beat_t hold;
    logic  hold_vld = 1'b0;
    vec_t  tbl[8];

    assign a_out.tready = out_rdy;
    assign b_out.tready = out_rdy;

    wire [3:0] mon_dat = use_b ? b_out.tdata  : a_out.tdata;
    wire       mon_vld = use_b ? b_out.tvalid : a_out.tvalid;
    wire       mon_lst = use_b ? b_out.tlast  : a_out.tlast;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output sink: always ready, or 5 stall cycles per beat.
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) begin
            out_rdy = 1'b1; stall = 0;
        end else if (!mon_vld) begin
            out_rdy = 1'b0; stall = 0;
        end else if (stall < 5) begin
            out_rdy = 1'b0; stall++;
        end else begin
            out_rdy = 1'b1; stall = 0;
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (hold_vld && mon_vld) begin
            chk("hold_tdata", mon_dat, hold.d);
            chk("hold_tlast", mon_lst, hold.l);
        end
        if (!mon_vld) chk("idle_tdata", mon_dat, 0);
        if (mon_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_beat: got %0h last=%0b, want none", mon_dat, mon_lst);
            end else begin
                e = exp_q.pop_front();
                chk("beat_tdata", mon_dat, e.d);
                chk("beat_tlast", mon_lst, e.l);
            end
            if (mon_lst) frames++;
        end
        hold_vld = mon_vld && !out_rdy;
        hold     = '{mon_dat, mon_lst};
    end

    task automatic push_frame(input logic [3:0] b0, input logic [3:0] b1);
        exp_q.push_back('{b0, 1'b0});
        exp_q.push_back('{b1, 1'b1});
    endtask

    // Returns #1 after the edge that accepted the beat presented on the selected input.
    task automatic wait_acc(input bit on_b);
        int n = 0;
        forever begin
            @(negedge clk);
            if (on_b ? b_in.tready : a_in.tready) begin
                @(posedge clk); #1;
                return;
            end
            n++;
            if (n > 100) begin
                n_cmp++; n_err++;
                $display("FAIL in_accept: got no tready, want tready within 100 cycles");
                return;
            end
        end
    endtask

    task automatic send_a(input logic [3:0] d);
        a_in.tdata = d; a_in.tvalid = 1'b1;
        wait_acc(1'b0);
        a_in.tvalid = 1'b0; a_in.tdata = '0;
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames < target && n < 200) begin
            @(negedge clk); n++;
        end
        chk("frame_done", frames, target);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset_check(input string tag);
        rst = 1'b0;
        #1;
        chk({tag, "_tvalid"}, a_out.tvalid, 0);
        chk({tag, "_tdata"},  a_out.tdata, 0);
        chk({tag, "_tlast"},  a_out.tlast, 0);
        chk({tag, "_tready"}, a_in.tready, 0);
        #1 rst = 1'b1;
    endtask

    initial begin
        int f0, cyc;
        tbl[0] = '{4'hB, 4'h5, 4'hA};
        tbl[1] = '{4'h0, 4'h0, 4'h0};
        tbl[2] = '{4'hF, 4'h7, 4'hF};
        tbl[3] = '{4'h8, 4'h4, 4'h6};
        tbl[4] = '{4'h1, 4'h0, 4'hF};
        tbl[5] = '{4'h6, 4'h3, 4'h6};
        tbl[6] = '{4'h4, 4'h2, 4'h5};
        tbl[7] = '{4'h2, 4'h1, 4'h3};
        a_in.tdata = '0; a_in.tvalid = 1'b0; a_in.tlast = 1'b0;
        b_in.tdata = '0; b_in.tvalid = 1'b0; b_in.tlast = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_tready", a_in.tready, 0);
        chk("rst_tvalid", a_out.tvalid, 0);
        chk("rst_tlast",  a_out.tlast, 0);
        chk("rst_tdata",  a_out.tdata, 0);
        chk("rst_b_tvalid", b_out.tvalid, 0);
        @(posedge clk); #1 rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            f0 = frames;
            push_frame(tbl[i].b0, tbl[i].b1);
            send_a(tbl[i].msg);
            cyc = 0;
            forever begin
                @(negedge clk);
                if (cyc == 0) chk("tready_encode", a_in.tready, 0);
                if (a_out.tvalid || cyc > 20) break;
                cyc++;
            end
            chk("latency", cyc, N_P);
            wait_frames(f0 + 1);
        end

        // Output backpressure: every beat held for 5 stalled cycles.
        rdy_mode = 1;
        f0 = frames;
        push_frame(4'h5, 4'hA);
        send_a(4'hB);
        wait_frames(f0 + 1);
        rdy_mode = 0;
        repeat (10) @(posedge clk);
        #1 chk("frame_once", frames, f0 + 1);

        // Back-to-back frames with tvalid held high.
        f0 = frames;
        push_frame(4'h5, 4'hA);
        push_frame(4'h7, 4'hF);
        a_in.tdata = 4'hB; a_in.tvalid = 1'b1;
        wait_acc(1'b0);
        a_in.tdata = 4'hF;
        cyc = 0;
        while (!a_in.tready && cyc < 100) begin
            @(negedge clk); cyc++;
        end
        chk("b2b_order", frames, f0 + 1);
        @(posedge clk); #1;
        a_in.tvalid = 1'b0; a_in.tdata = '0;
        wait_frames(f0 + 2);

        // Reset during ENCODE, second cycle: frame must vanish.
        send_a(4'hB);
        @(posedge clk); #2;
        pulse_reset_check("rst_encode");
        repeat (12) @(posedge clk);
        #1 chk("q_after_enc_rst", exp_q.size(), 0);

        // Reset while beat 1 is stalled on the output.
        rdy_mode = 1;
        exp_q.push_back('{4'h5, 1'b0});
        send_a(4'hB);
        cyc = 0;
        forever begin
            @(negedge clk);
            if ((a_out.tvalid && a_out.tlast) || cyc > 100) break;
            cyc++;
        end
        chk("beat1_seen", a_out.tlast, 1);
        #1;
        pulse_reset_check("rst_write");
        rdy_mode = 0;
        repeat (12) @(posedge clk);
        #1 chk("q_after_wr_rst", exp_q.size(), 0);

        f0 = frames;
        push_frame(4'h5, 4'hA);
        send_a(4'hB);
        wait_frames(f0 + 1);

        // 2-bit input with an idle cycle between beats.
        use_b = 1'b1;
        f0 = frames;
        push_frame(4'h5, 4'hA);
        b_in.tdata = 2'b10; b_in.tvalid = 1'b1;
        wait_acc(1'b1);
        b_in.tvalid = 1'b0; b_in.tdata = '0;
        @(posedge clk); #1;
        b_in.tdata = 2'b11; b_in.tvalid = 1'b1;
        wait_acc(1'b1);
        b_in.tvalid = 1'b0; b_in.tdata = '0;
        wait_frames(f0 + 1);
        use_b = 1'b0;

        chk("q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ldpc_encoder_top.md
# ldpc_encoder_top

Systematic LDPC encoder feeding the channel/LLR-generation side of the link ahead of the min-sum decoder. It accepts K message bits over an AXI-stream slave and computes the N_V-K parity bits serially from a parity mask matrix. It then returns the N_V-bit codeword over an AXI-stream master, using the same segment packing the decoder uses for its codeword output.

## Interface
- K, `K`, message length in bits
- N_V, `N_V`, codeword length in bits (N_P = N_V-K parity bits, N_P ≥ 1)
- Stream widths come from the interfaces: from_env.WIDTH (W_IN), to_env.WIDTH (W_OUT)
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- from_env  axi_stream_if.slave  W_IN  message beats (tdata, tvalid, tready; tlast ignored)
- to_env  axi_stream_if.master  W_OUT  codeword beats (tdata, tvalid, tready, tlast)

## Operation
- Derived constants:
  - IN_ITER_N = ceil(K/W_IN)
  - OUT_ITER_N = ceil(N_V/W_OUT)
  - IN_PAD = (K-1)%W_IN+1
  - OUT_PAD = (N_V-1)%W_OUT+1
- Bit order: message bit 0 sits at the MSB of the K-bit message register and is received first. Codeword bit 0 sits at the MSB of the N_V-bit output register and is sent first.
- Codeword: bits 0..K-1 are the message bits. Bit K+j is the parity bit p_j = XOR over i of (m_i AND PARITY_MASK[j][i]).
- States: RESET → READ → ENCODE → WRITE → READ.
- RESET:
  - Entered on reset assertion.
  - Moves to READ on the first clk edge after release.
- READ:
  - tready=1.
  - On each beat (tvalid&&tready): msg = {msg, tdata} truncated to K bits; seg counter increments.
  - Only the low IN_PAD bits of the first beat are meaningful.
  - After beat IN_ITER_N-1: counter clears, go to ENCODE.
- ENCODE:
  - tready=0, tvalid=0.
  - One parity bit per cycle: p_cnt = 0..N_P-1; parity[p_cnt] is registered.
  - After p_cnt = N_P-1: load the output register with {msg, parity}, clear counters, go to WRITE.
- WRITE:
  - tvalid=1.
  - Beat 0 carries the top OUT_PAD codeword bits in tdata[OUT_PAD-1:0], with upper bits 0.
  - Each later beat carries the next W_OUT bits, MSB-first.
  - tlast=1 on beat OUT_ITER_N-1 for as long as that beat is presented.
  - On tready: shift the register by OUT_PAD (beat 0) or W_OUT, and advance the counter.
  - After the last accepted beat, go to READ.
- to_env.tdata is driven to 0 (not z) whenever tvalid=0.

## Timing
- Reset values: from_env.tready=0, to_env.tvalid=0, to_env.tlast=0, to_env.tdata=0. All registers clear to 0.
- Reset asserted mid-frame (any state) discards the partial message, parity and codeword immediately. No beat is emitted afterwards.
- Input accepts one beat per cycle with no bubbles.
- Latency: if the last input beat is accepted at edge T, tvalid rises after edge T+N_P.
- Output data and tlast stay stable while tvalid=1 && tready=0.
- Back-to-back frames: tready is low from the final input beat until the final output beat is accepted. READ resumes the cycle after that.
- Input tvalid while not in READ is ignored (tready=0). No beat is dropped or partially consumed.

## Structure
- Package ldpc_code_pkg holds:
  - K, N_V, N_P
  - PARITY_MASK as logic [N_P-1:0][K-1:0]
  - the state enum (RESET, READ, ENCODE, WRITE)
  - the INT_SIZE counter width
- Sub-module ldpc_parity_unit is combinational: inputs msg[K-1:0] and row index, output one parity bit = ^(msg & PARITY_MASK[idx]).
- Top holds the FSM, the message, parity and output shift registers, and the counters.

## Test plan
Configuration: Hamming(7,4) package, W_IN=4, W_OUT=4. Masks: p0 = m0^m1^m3, p1 = m0^m2^m3, p2 = m1^m2^m3.
- Message 4'hB (m=1011) → 3 encode cycles, then beats 4'h5 (tlast=0) and 4'hA (tlast=1).
- Message 4'h0 → beats 4'h0, 4'h0 with tlast on the second beat. Message 4'hF → beats 4'h7, 4'hF.
- Output backpressure: hold tready=0 for 5 cycles on each beat → tdata/tlast stable throughout, correct codeword, frame ends exactly once.
- Back-to-back frames 4'hB then 4'hF, with tvalid held high continuously → second beat not accepted until first frame's tlast handshake. Outputs 5,A then 7,F.
- Async reset pulsed during ENCODE (cycle 2) and during WRITE beat 1 → outputs return to 0 without a clk edge. Next frame 4'hB encodes correctly to 5,A.
- Input tvalid gaps (one idle cycle per beat) with W_IN=2, K=4 → message 2'b10, 2'b11 assembles 4'hB and yields 5,A.
